prescaler_timer_multi: RTL
==========================

# prescaler_timer_multi

Multi-channel successor to the single prescaler timer: NUM_CHANNELS independent power-of-two countdown timers sharing one clock. Each channel has its own prescaler, enable, timer reset, output mode (toggle or single-cycle pulse), one-shot option and done flag. Prescaler changes are shadowed and take effect only at a period boundary. Sits between the register file and the pulse-transmitter channels, which consume `out` as their bit/carrier clock enable.

## Interface
- NUM_CHANNELS, default 4: number of independent timer channels (1..16).
- PRESCALER_NUM_BITS, default 4: width of each channel's prescaler field; counter width CW = 2**PRESCALER_NUM_BITS.
- clk  input  1  system clock; all logic on rising edge.
- sys_rst  input  1  synchronous, active-high reset; one clock, reset is synchronous and active-high.
- en  input  NUM_CHANNELS  per-channel count enable; low freezes the channel.
- tim_rst  input  NUM_CHANNELS  per-channel synchronous timer reset; holds channel idle while high.
- prescaler  input  NUM_CHANNELS*PRESCALER_NUM_BITS  channel i in bits [i*PB +: PB].
- mode  input  NUM_CHANNELS  0 = toggle (square wave), 1 = pulse (one-cycle strobe).
- one_shot  input  NUM_CHANNELS  1 = stop after first expiry.
- out  output  NUM_CHANNELS  registered timer output.
- done  output  NUM_CHANNELS  registered; 1 once a one-shot channel has expired.

## Operation
- Per channel i: shadow prescaler p (PB bits), down-counter cnt (CW bits), state IDLE / RUN / DONE, registered out/done.
- Half-period H = 2^(p-1) enabled cycles for p >= 1. Width rule: H-1 fits in CW-1 bits for all p; no overflow.
- sys_rst: all channels IDLE, cnt = 0, p = 0, out = 0, done = 0. Overrides everything.
- tim_rst[i] high (priority over en): state IDLE, out = 0, done = 0, p <= prescaler[i], cnt <= H(prescaler[i]) - 1.
- IDLE -> RUN on first edge with tim_rst low and en high; that edge is enabled edge #1.
- RUN, en high: cnt decrements each edge; when cnt == 0 at an enabled edge = expiry: cnt reloads H(new p)-1, p <= prescaler[i] (shadow update), and:
  - mode 0: out <= ~out.
  - mode 1: out <= 1 for exactly one cycle, 0 otherwise.
  - one_shot 1: state -> DONE, done <= 1; mode 0 holds out = 1, mode 1 returns out to 0 next cycle.
- RUN, en low: cnt and p frozen; mode 0 out held; mode 1 out forced 0.
- DONE: counter frozen, no further expiries until tim_rst[i] or sys_rst.
- p == 0 in RUN: out = 1 every enabled cycle (both modes); one_shot with p == 0: done <= 1 on first enabled edge, out = 1 that cycle then per mode rules above.
- mode and one_shot are sampled live; changing mode mid-run takes effect at the next edge, out is not glitch-corrected.
- Channels fully independent; no shared state except clk/sys_rst.

## Timing
- All outputs registered; reset value out = 0, done = 0 on every channel.
- First expiry at enabled edge #H after tim_rst release; out/done visible the cycle after that edge.
- Mode 0 steady state: out high H enabled cycles, low H enabled cycles (period 2H). Mode 1: one-cycle pulse every H enabled cycles.
- Prescaler write during RUN: current half-period completes at old H; next half-period uses new H. Write at same edge as expiry is captured.
- tim_rst asserted mid-period: out = 0 next cycle, count discarded.
- tim_rst and expiry on same edge: tim_rst wins.
- en deasserted on the expiry edge: expiry does not occur; resumes at next enabled edge.
- sys_rst mid-operation: all channels return to reset values next cycle regardless of tim_rst/en.

## Test plan
- NUM_CHANNELS=4, PB=4; ch0 p=2 mode 0, en=1, release tim_rst -> out low 2 cycles, high 2, low 2 repeating; ch1 p=0 -> out constant 1 from first enabled cycle.
- ch2 p=3 mode 1 -> single-cycle pulse every 4 cycles, first pulse visible after enabled edge #4; en low for 3 cycles mid-count -> next pulse delayed exactly 3 cycles, out 0 while en low.
- ch0 p=2 running, write p=4 mid half-period -> current half-period stays 2 cycles, subsequent half-periods 8 cycles.
- ch3 p=1 mode 0 one_shot=1 -> out rises after enabled edge #1, done=1 same cycle, both hold; tim_rst pulse -> out=0, done=0, channel restarts.
- tim_rst asserted on same edge as ch0 expiry -> no toggle, out=0 next cycle; sys_rst during all channels running -> all out/done = 0 next cycle.
- p=15 (max, PB=4) mode 1 -> pulses exactly 16384 cycles apart, no counter wrap.

Source files
------------

// File: rtl/prescaler_timer_multi.sv
// NUM_CHANNELS independent power-of-two countdown timers with shadowed prescalers.
// Each channel drives a toggle or pulse output plus a one-shot done flag.

module prescaler_timer_ch #(
   parameter int PB = 4
) (
   input  logic          clk,
   input  logic          sys_rst,
   input  logic          tim_rst,
   input  logic          en,
   input  logic          mode,
   input  logic          one_shot,
   input  logic [PB-1:0] prescaler,
   output logic          out,
   output logic          done
);
   localparam int CW = 2**PB;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state_q, state_d;
   logic [PB-1:0] p_q, p_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          out_q, out_d;
   logic          done_q, done_d;
   logic [CW-1:0] reload_m1;

   // H-1 for the incoming prescaler; p == 0 behaves as a one-cycle period.
   function automatic logic [CW-1:0] half_m1(input logic [PB-1:0] p);
      if (p == '0) return '0;
      return (CW'(1) << (p - PB'(1))) - CW'(1);
   endfunction

   assign reload_m1 = half_m1(prescaler);

   always_comb begin
      state_d = state_q;
      p_d     = p_q;
      cnt_d   = cnt_q;
      out_d   = out_q;
      done_d  = done_q;
      if (tim_rst) begin
         state_d = IDLE;
         out_d   = 1'b0;
         done_d  = 1'b0;
         p_d     = prescaler;
         cnt_d   = reload_m1;
      end else begin
         if (mode) out_d = 1'b0;
         if (en && state_q != DONE) begin
            state_d = RUN;
            if (cnt_q == '0) begin
               cnt_d = reload_m1;
               p_d   = prescaler;
               out_d = (p_q == '0 || mode) ? 1'b1 : ~out_q;
               if (one_shot) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (sys_rst) begin
         state_q <= IDLE;
         p_q     <= '0;
         cnt_q   <= '0;
         out_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         p_q     <= p_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
         done_q  <= done_d;
      end
   end

   assign out  = out_q;
   assign done = done_q;
endmodule

module prescaler_timer_multi #(
   parameter int NUM_CHANNELS       = 4,
   parameter int PRESCALER_NUM_BITS = 4
) (
   input  logic                                       clk,
   input  logic                                       sys_rst,
   input  logic [NUM_CHANNELS-1:0]                    en,
   input  logic [NUM_CHANNELS-1:0]                    tim_rst,
   input  logic [NUM_CHANNELS*PRESCALER_NUM_BITS-1:0] prescaler,
   input  logic [NUM_CHANNELS-1:0]                    mode,
   input  logic [NUM_CHANNELS-1:0]                    one_shot,
   output logic [NUM_CHANNELS-1:0]                    out,
   output logic [NUM_CHANNELS-1:0]                    done
);
   for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
      prescaler_timer_ch #(.PB(PRESCALER_NUM_BITS)) u_ch (
         .clk       (clk),
         .sys_rst   (sys_rst),
         .tim_rst   (tim_rst[i]),
         .en        (en[i]),
         .mode      (mode[i]),
         .one_shot  (one_shot[i]),
         .prescaler (prescaler[i*PRESCALER_NUM_BITS +: PRESCALER_NUM_BITS]),
         .out       (out[i]),
         .done      (done[i])
      );
   end
endmodule
